// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV M-extension multiply/divide for the EX stage
module ex_muldiv_unit #(
  parameter int XLEN = 64,
  parameter int REG_COUNT = 32,
  localparam int RW = $clog2(REG_COUNT),
  localparam int CW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [RW-1:0]   rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [RW-1:0]   rd_addr_out
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] op;
  logic neg;
  logic [XLEN-1:0] opa;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [RW-1:0] rd_q;
  logic sgn_a, sgn_b, neg_in, div0, ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_val, part, fin;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0] sum, rsh, diff;
  always_comb begin
    sgn_a = rs1_in[XLEN-1] & (funct3_in == 3'b001 || funct3_in == 3'b010 || (funct3_in[2] && !funct3_in[0]));
    sgn_b = rs2_in[XLEN-1] & (funct3_in == 3'b001 || (funct3_in[2] && !funct3_in[0]));
    mag_a = sgn_a ? -rs1_in : rs1_in;
    mag_b = sgn_b ? -rs2_in : rs2_in;
    neg_in = (funct3_in[2] && funct3_in[1]) ? sgn_a : sgn_a ^ sgn_b;
    div0 = funct3_in[2] && rs2_in == '0;
    ovf = funct3_in[2] && !funct3_in[0] && rs1_in == {1'b1, {(XLEN-1){1'b0}}} && &rs2_in;
    special = div0 || ovf;
    special_val = div0 ? (funct3_in[1] ? rs1_in : '1) : (funct3_in[1] ? '0 : rs1_in);
    accept = start && !flush && (state == IDLE || state == DONE);
  end
  // Multiply shifts {carry,hi,lo} right; divide shifts the remainder/quotient pair left
  always_comb begin
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : '0);
    rsh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = rsh - {1'b0, opa};
    acc_nx = op[2] ? (diff[XLEN] ? {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                   : {sum, acc[XLEN-1:1]};
    prod = neg ? -acc_nx : acc_nx;
    part = op[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    fin = op[2] ? (neg ? -part : part) : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_comb begin
    state_nx = IDLE;
    if (!flush) state_nx = accept ? (special ? DONE : CALC) : (state == CALC ? (cnt == '0 ? DONE : CALC) : IDLE);
    busy = state == CALC || (state == IDLE && start);
    result_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      neg <= 1'b0;
      opa <= '0;
      acc <= '0;
      rd_q <= '0;
      result <= '0;
      rd_addr_out <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= funct3_in;
        neg <= neg_in;
        rd_q <= rd_addr_in;
        cnt <= CW'(XLEN-1);
        opa <= funct3_in[2] ? mag_b : mag_a;
        acc <= {{XLEN{1'b0}}, funct3_in[2] ? mag_a : mag_b};
        if (special) begin
          result <= special_val;
          rd_addr_out <= rd_addr_in;
        end
      end else if (state == CALC && !flush) begin
        acc <= acc_nx;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          result <= fin;
          rd_addr_out <= rd_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed checks of the mul/div unit at XLEN 64 and 32
module tb_ex_muldiv_unit;
  logic clk = 0, rst = 1, start64 = 0, start32 = 0, flush = 0;
  logic [2:0] f3 = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [4:0] rd = '0;
  logic busy64, rv64, busy32, rv32;
  logic [63:0] res64;
  logic [31:0] res32;
  logic [4:0] rdo64, rdo32;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(64), .REG_COUNT(32)) u64 (
    .clk(clk), .rst(rst), .start(start64), .funct3_in(f3), .rs1_in(rs1), .rs2_in(rs2),
    .rd_addr_in(rd), .flush(flush), .busy(busy64), .result_valid(rv64), .result(res64),
    .rd_addr_out(rdo64));

  ex_muldiv_unit #(.XLEN(32), .REG_COUNT(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .funct3_in(f3), .rs1_in(rs1[31:0]), .rs2_in(rs2[31:0]),
    .rd_addr_in(rd), .flush(flush), .busy(busy32), .result_valid(rv32), .result(res32),
    .rd_addr_out(rdo32));

  // Reference: exact wide integer arithmetic, then truncate to xl bits
  function automatic logic [63:0] ref_model(input int xl, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] sa, sb, ua, ub, p;
    logic [129:0] m;
    m = (130'd1 << xl) - 130'd1;
    ua = $signed({66'd0, a});
    ub = $signed({66'd0, b});
    sa = (xl == 64) ? $signed({{66{a[63]}}, a}) : $signed({{98{a[31]}}, a[31:0]});
    sb = (xl == 64) ? $signed({{66{b[63]}}, b}) : $signed({{98{b[31]}}, b[31:0]});
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> xl;
      3'd2: p = (sa * ub) >>> xl;
      3'd3: p = (ua * ub) >>> xl;
      3'd4: p = (b == 0) ? -130'sd1 : sa / sb;
      3'd5: p = (b == 0) ? -130'sd1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return 64'(p & m);
  endfunction

  task automatic run_op(input int w, input bit b2b, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] r, output logic [63:0] got,
                        output logic [4:0] got_rd, output int lat, output int bc);
    if (!b2b) @(negedge clk);
    f3 = f; rs1 = a; rs2 = b; rd = r;
    if (w == 64) start64 = 1; else start32 = 1;
    lat = -1; bc = 0; got = '0; got_rd = '0;
    #1;
    if (w == 64 ? busy64 : busy32) bc++;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start64 = 0; start32 = 0;
      #1;
      if (w == 64 ? rv64 : rv32) begin
        lat = i;
        got = (w == 64) ? res64 : {32'd0, res32};
        got_rd = (w == 64) ? rdo64 : rdo32;
        break;
      end
      if (w == 64 ? busy64 : busy32) bc++;
    end
  endtask

  task automatic test_reset;
    #2 rst = 0;
    #1;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy64); end
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rv64); end
    checks++; if (res64 !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", res64); end
    checks++; if (rdo64 !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rdo64); end
    checks++; if (rv32 !== 1'b0 || res32 !== 32'd0) begin errors++; $display("FAIL reset_32: got v=%b r=%h want 0/0", rv32, res32); end
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_mul;
    logic [63:0] got; logic [4:0] grd; int lat, bc;
    run_op(64, 0, 3'd0, 64'd7, -64'sd3, 5'd5, got, grd, lat, bc);
    checks++; if (got !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_7x-3: got %h want ffffffffffffffeb", got); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL mul_latency: got %0d want 65", lat); end
    checks++; if (bc !== 65) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 65", bc); end
    checks++; if (grd !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d want 5", grd); end
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL mul_busy_in_done: got %b want 0", busy64); end
    @(negedge clk); #1;
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL mul_valid_one_cycle: got %b want 0", rv64); end
    checks++; if (res64 !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h want ffffffffffffffeb", res64); end
  endtask

  task automatic test_mulh;
    logic [2:0] tf [3] = '{3'd3, 3'd1, 3'd2};
    logic [63:0] ta [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] tb [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    logic [63:0] te [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] got; logic [4:0] grd; int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_op(64, 0, tf[i], ta[i], tb[i], 5'(i + 1), got, grd, lat, bc);
      checks++; if (got !== te[i]) begin errors++; $display("FAIL mulh_%0d: got %h want %h", i, got, te[i]); end
    end
  endtask

  task automatic test_div;
    logic [2:0] tf [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [63:0] ta [4] = '{-64'sd7, -64'sd7, 64'd100, 64'd100};
    logic [63:0] tb [4] = '{64'd2, 64'd2, 64'd7, 64'd7};
    logic [63:0] te [4] = '{-64'sd3, -64'sd1, 64'd14, 64'd2};
    logic [63:0] got; logic [4:0] grd; int lat, bc;
    for (int i = 0; i < 4; i++) begin
      run_op(64, 0, tf[i], ta[i], tb[i], 5'(20 + i), got, grd, lat, bc);
      checks++; if (got !== te[i]) begin errors++; $display("FAIL div_%0d: got %h want %h", i, got, te[i]); end
      checks++; if (grd !== 5'(20 + i)) begin errors++; $display("FAIL div_rd_%0d: got %0d want %0d", i, grd, 20 + i); end
      checks++; if (lat !== 65) begin errors++; $display("FAIL div_latency_%0d: got %0d want 65", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [2:0] tf [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [63:0] ta [6] = '{64'd5, 64'd5, 64'd5, 64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] tb [6] = '{64'd0, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] te [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000, 64'd0};
    logic [63:0] got; logic [4:0] grd; int lat, bc;
    for (int i = 0; i < 6; i++) begin
      run_op(64, 0, tf[i], ta[i], tb[i], 5'(10 + i), got, grd, lat, bc);
      checks++; if (got !== te[i]) begin errors++; $display("FAIL special_%0d: got %h want %h", i, got, te[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency_%0d: got %0d want 1", i, lat); end
      checks++; if (grd !== 5'(10 + i)) begin errors++; $display("FAIL special_rd_%0d: got %0d want %0d", i, grd, 10 + i); end
    end
  endtask

  task automatic test_flush;
    logic [63:0] got, held; logic [4:0] grd; int lat, bc; bit seen;
    held = res64;
    @(negedge clk);
    f3 = 3'd4; rs1 = 64'd1000; rs2 = 64'd7; rd = 5'd3; start64 = 1;
    @(negedge clk);
    start64 = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    #1;
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy64); end
    seen = rv64;
    repeat (80) begin
      @(negedge clk); #1;
      if (rv64) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b want 0", seen); end
    checks++; if (res64 !== held) begin errors++; $display("FAIL flush_result_hold: got %h want %h", res64, held); end
    run_op(64, 0, 3'd0, 64'd3, 64'd4, 5'd9, got, grd, lat, bc);
    checks++; if (got !== 64'd12) begin errors++; $display("FAIL flush_then_mul: got %h want c", got); end
    checks++; if (lat !== 65) begin errors++; $display("FAIL flush_then_mul_latency: got %0d want 65", lat); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] ga, gb, a1, b1, a2, b2; logic [4:0] grd; int la, lb, bc;
    @(negedge clk);
    f3 = 3'd5; rs1 = 64'h0123_4567_89AB_CDEF; rs2 = 64'd3; rd = 5'd7; start64 = 1;
    @(negedge clk);
    start64 = 0;
    repeat (20) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++; if (busy64 !== 1'b0 || rv64 !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got busy=%b valid=%b want 0/0", busy64, rv64); end
    checks++; if (res64 !== 64'd0 || rdo64 !== 5'd0) begin errors++; $display("FAIL midreset_data: got %h rd=%0d want 0/0", res64, rdo64); end
    @(negedge clk);
    rst = 1;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = 64'($urandom_range(1, 1000));
    run_op(64, 0, 3'd3, a1, b1, 5'd17, ga, grd, la, bc);
    run_op(64, 1, 3'd4, a2, b2, 5'd18, gb, grd, lb, bc);
    checks++; if (ga !== ref_model(64, 3'd3, a1, b1)) begin errors++; $display("FAIL b2b_first: got %h want %h", ga, ref_model(64, 3'd3, a1, b1)); end
    checks++; if (gb !== ref_model(64, 3'd4, a2, b2)) begin errors++; $display("FAIL b2b_second: got %h want %h", gb, ref_model(64, 3'd4, a2, b2)); end
    checks++; if (la !== 65 || lb !== 65) begin errors++; $display("FAIL b2b_latency: got %0d/%0d want 65/65", la, lb); end
    checks++; if (bc !== 64) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 64", bc); end
    checks++; if (grd !== 5'd18) begin errors++; $display("FAIL b2b_rd: got %0d want 18", grd); end
  endtask

  task automatic test_random(input int w, input int n);
    logic [63:0] a, b, m, mn, got, exp; logic [2:0] f; logic [4:0] r, grd; int lat, bc, sel, explat;
    longint t;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    mn = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
    for (int i = 0; i < n; i++) begin
      f = 3'($urandom_range(0, 7));
      r = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (sel == 0) b = '0;
      if (sel == 1) begin a = mn; b = m; end
      if (sel == 2) begin
        t = longint'($urandom_range(0, 200)) - 100; a = t;
        t = longint'($urandom_range(0, 20)) - 10; b = t;
      end
      a &= m; b &= m;
      exp = ref_model(w, f, a, b);
      explat = (f[2] && (b == 0 || (!f[0] && a == mn && b == m))) ? 1 : w + 1;
      run_op(w, 0, f, a, b, r, got, grd, lat, bc);
      checks++; if (got !== exp || grd !== r || lat !== explat) begin
        errors++;
        $display("FAIL rand%0d_%0d f=%0d a=%h b=%h: got %h rd=%0d lat=%0d want %h rd=%0d lat=%0d",
                 w, i, f, a, b, got, grd, lat, exp, r, explat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_back_to_back;
    test_random(64, 40);
    test_random(32, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
